// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path:
// state encodings, opcodes, ALUOp / RegDst / PCSrc codes, control bundle.
package mc_cpu_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100000;
  localparam logic [5:0] OP_SLTI  = 6'b100001;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       insmemrw;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrregdsrc;
    logic       alusrca;
    logic       alusrcb;
    logic       extsel;
    logic [2:0] aluop;
    logic       dbdatasrc;
    logic       mrd;
    logic       mwr;
    logic [1:0] pcsrc;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] aluop;
    logic       srca;
    logic       imm;
    logic       ext;
  } alu_cfg_t;

  // ALU-group lookup: valid=0 means the opcode is not an ALU instruction.
  function automatic alu_cfg_t alu_cfg(input logic [5:0] op);
    alu_cfg_t c;
    c = '0;
    c.valid = 1'b1;
    case (op)
      OP_ADD:   c.aluop = ALU_ADD;
      OP_SUB:   c.aluop = ALU_SUB;
      OP_ADDIU: begin
        c.aluop = ALU_ADD;
        c.imm   = 1'b1;
        c.ext   = 1'b1;
      end
      OP_AND:   c.aluop = ALU_AND;
      OP_ANDI:  begin
        c.aluop = ALU_AND;
        c.imm   = 1'b1;
      end
      OP_ORI:   begin
        c.aluop = ALU_OR;
        c.imm   = 1'b1;
      end
      OP_XORI:  begin
        c.aluop = ALU_XOR;
        c.imm   = 1'b1;
      end
      OP_SLL:   begin
        c.aluop = ALU_SLL;
        c.srca  = 1'b1;
      end
      OP_SLT:   c.aluop = ALU_SLT;
      OP_SLTI:  begin
        c.aluop = ALU_SLT;
        c.imm   = 1'b1;
        c.ext   = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: (state, opCode, zero, sign) -> control
// bundle, next state and halt request. i_en=0 forces every output idle.
module mc_ctrl_decode
  import mc_cpu_pkg::*;
#(
  parameter int               OPC_W    = 6,
  parameter logic [OPC_W-1:0] HALT_OPC = 6'b111111
) (
  input  logic             i_en,
  input  state_e           i_state,
  input  logic [OPC_W-1:0] i_op,
  input  logic             i_zero,
  input  logic             i_sign,
  output ctrl_t            o_ctrl,
  output state_e           o_next,
  output logic             o_set_halt
);

  alu_cfg_t w_alu;
  logic     w_j;
  logic     w_jr;
  logic     w_jal;
  logic     w_br;
  logic     w_sw;
  logic     w_lw;
  logic     w_taken;

  assign w_alu = alu_cfg(i_op);
  assign w_j   = (i_op == OP_J);
  assign w_jr  = (i_op == OP_JR);
  assign w_jal = (i_op == OP_JAL);
  assign w_br  = (i_op == OP_BEQ) ||
                 (i_op == OP_BNE) ||
                 (i_op == OP_BLTZ);
  assign w_sw  = (i_op == OP_SW);
  assign w_lw  = (i_op == OP_LW);

  assign w_taken = ((i_op == OP_BEQ)  &&  i_zero) ||
                   ((i_op == OP_BNE)  && !i_zero) ||
                   ((i_op == OP_BLTZ) &&  i_sign);

  always_comb begin
    o_ctrl     = '0;
    o_next     = S_IF;
    o_set_halt = 1'b0;
    if (i_en) begin
      unique case (i_state)
        S_IF: begin
          o_ctrl.insmemrw = 1'b1;
          o_ctrl.irwre    = 1'b1;
          o_next          = S_ID;
        end
        S_ID: begin
          if (i_op == HALT_OPC) begin
            o_set_halt = 1'b1;
          end else begin
            unique case (1'b1)
              w_j: begin
                o_ctrl.pcsrc = PC_J;
                o_ctrl.pcwre = 1'b1;
              end
              w_jr: begin
                o_ctrl.pcsrc = PC_JR;
                o_ctrl.pcwre = 1'b1;
              end
              w_jal: begin
                o_ctrl.pcsrc     = PC_J;
                o_ctrl.pcwre     = 1'b1;
                o_ctrl.regwre    = 1'b1;
                o_ctrl.regdst    = RD_RA;
                o_ctrl.wrregdsrc = 1'b0;
              end
              w_br:      o_next = S_EXE_BR;
              w_sw,
              w_lw:      o_next = S_EXE_LS;
              w_alu.valid: o_next = S_EXE_AL;
              default: begin
                o_ctrl.pcwre = 1'b1;
                o_ctrl.pcsrc = PC_SEQ;
              end
            endcase
          end
        end
        S_EXE_AL: begin
          o_ctrl.aluop   = w_alu.aluop;
          o_ctrl.alusrca = w_alu.srca;
          o_ctrl.alusrcb = w_alu.imm;
          o_ctrl.extsel  = w_alu.ext;
          o_next         = S_WB_AL;
        end
        S_WB_AL: begin
          o_ctrl.regwre    = 1'b1;
          o_ctrl.wrregdsrc = 1'b1;
          o_ctrl.dbdatasrc = 1'b0;
          o_ctrl.pcwre     = 1'b1;
          o_ctrl.pcsrc     = PC_SEQ;
          o_ctrl.regdst    = w_alu.imm ? RD_RT : RD_RD;
        end
        S_EXE_BR: begin
          o_ctrl.aluop  = ALU_SUB;
          o_ctrl.extsel = 1'b1;
          o_ctrl.pcwre  = 1'b1;
          o_ctrl.pcsrc  = w_taken ? PC_BR : PC_SEQ;
        end
        S_EXE_LS: begin
          o_ctrl.aluop   = ALU_ADD;
          o_ctrl.alusrcb = 1'b1;
          o_ctrl.extsel  = 1'b1;
          o_next         = S_MEM;
        end
        S_MEM: begin
          if (w_lw) begin
            o_ctrl.mrd = 1'b1;
            o_next     = S_WB_LD;
          end else begin
            // Only sw reaches here; PCWre keeps one-pulse-per-instruction.
            o_ctrl.mwr   = w_sw;
            o_ctrl.pcwre = 1'b1;
          end
        end
        S_WB_LD: begin
          o_ctrl.mrd       = 1'b1;
          o_ctrl.dbdatasrc = 1'b1;
          o_ctrl.regwre    = 1'b1;
          o_ctrl.regdst    = RD_RT;
          o_ctrl.wrregdsrc = 1'b1;
          o_ctrl.pcwre     = 1'b1;
        end
        default: o_next = S_IF;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: holds state and halt registers and
// drives every datapath enable/select from the decode sub-module.
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter int               OPC_W    = 6,
  parameter logic [OPC_W-1:0] HALT_OPC = 6'b111111
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [OPC_W-1:0] opCode,
  input  logic             funct_jr,
  input  logic             zero,
  input  logic             sign,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [1:0]       PCSrc,
  output logic [2:0]       state
);

  state_e r_state;
  logic   r_halt;
  state_e w_next;
  logic   w_set_halt;
  logic   w_en;
  ctrl_t  w_ctrl;
  logic   w_unused;

  assign w_unused = funct_jr;

  // Reset and halt both force every output (including state) to idle.
  assign w_en = !Reset && !r_halt;

  mc_ctrl_decode #(
    .OPC_W    (OPC_W),
    .HALT_OPC (HALT_OPC)
  ) u_dec (
    .i_en       (w_en),
    .i_state    (r_state),
    .i_op       (opCode),
    .i_zero     (zero),
    .i_sign     (sign),
    .o_ctrl     (w_ctrl),
    .o_next     (w_next),
    .o_set_halt (w_set_halt)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IF;
      r_halt  <= 1'b0;
    end else if (!r_halt) begin
      r_state <= w_next;
      if (w_set_halt) r_halt <= 1'b1;
    end
  end

  assign PCWre     = w_ctrl.pcwre;
  assign IRWre     = w_ctrl.irwre;
  assign InsMemRW  = w_ctrl.insmemrw;
  assign RegWre    = w_ctrl.regwre;
  assign RegDst    = w_ctrl.regdst;
  assign WrRegDSrc = w_ctrl.wrregdsrc;
  assign ALUSrcA   = w_ctrl.alusrca;
  assign ALUSrcB   = w_ctrl.alusrcb;
  assign ExtSel    = w_ctrl.extsel;
  assign ALUOp     = w_ctrl.aluop;
  assign DBDataSrc = w_ctrl.dbdatasrc;
  assign mRD       = w_ctrl.mrd;
  assign mWR       = w_ctrl.mwr;
  assign PCSrc     = w_ctrl.pcsrc;
  assign state     = w_en ? r_state : S_IF;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit that sequences the existing single-cycle datapath (PC, instruction memory, register file, ALU, data memory) as a 5-phase machine: IF/ID/EXE/MEM/WB.
- Decodes the IR opcode together with the current state, and drives every write-enable and mux select, one phase per clk.
- Sits between the IR/ALU flags and the datapath control pins; it replaces the combinational ControlUnit in the multi-cycle CPU top.

Parameters:
- OPC_W, 6, opcode width.
- HALT_OPC, 6'b111111, opcode that parks the machine in sHALT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- opCode  in  6  IR[31:26]; stable from ID onward.
- funct_jr  in  1  unused (tie 0); reserved.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  1 = read instruction memory.
- RegWre  out  1  register file write enable.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB.
- ALUSrcA  out  1  1 = shamt.
- ALUSrcB  out  1  1 = extended immediate.
- ExtSel  out  1  1 = sign-extend.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt, 111 xor.
- DBDataSrc  out  1  1 = data memory output.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  00 = PC+4, 01 = branch, 10 = jr, 11 = jump.
- state  out  3  current state, for debug.

Behaviour:
- State encoding:
  - sIF 000
  - sID 001
  - sEXE_LS 010
  - sMEM 011
  - sWB_LD 100
  - sEXE_BR 101
  - sEXE_AL 110
  - sWB_AL 111
  - sHALT is a separate sticky flag; when set, state holds 000.
- Reset: on a clk edge with Reset=1, state goes to sIF and halt clears.
  - Outputs while Reset=1: PCWre=0, RegWre=0, mWR=0, IRWre=0; all other outputs 0.
  - The first cycle after Reset falls is sIF.
  - Reset asserted mid-instruction aborts it; no write enable asserts in the reset cycle.
- sIF: InsMemRW=1, IRWre=1 -> sID.
- sID, dispatch on opCode:
  - j (111000): PCSrc=11, PCWre=1 -> sIF.
  - jr (111001): PCSrc=10, PCWre=1 -> sIF.
  - jal (111010): PCSrc=11, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=0 -> sIF.
  - HALT_OPC: set halt; PCWre=0; stay in sIF with IRWre=0 and all enables 0 until Reset.
  - beq (110000), bne (110001), bltz (110010) -> sEXE_BR.
  - sw (100110), lw (100111) -> sEXE_LS.
  - ALU group -> sEXE_AL:
    - add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slt 100000, slti 100001.
  - Any other opcode is a nop: PCWre=1, PCSrc=00 -> sIF.
- sEXE_AL: ALUOp per opcode.
  - ALUSrcB=1 for immediate forms.
  - ALUSrcA=1 for sll.
  - ExtSel=1 for addiu/slti; 0 for andi/ori/xori.
  - -> sWB_AL.
- sWB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
  - RegDst=10 for R-type, 01 for immediate forms.
  - -> sIF.
- sEXE_BR: ALUOp=001 (sub), ExtSel=1, PCWre=1.
  - PCSrc=01 if taken, else 00.
  - Taken: beq when zero=1; bne when zero=0; bltz when sign=1.
  - -> sIF.
- sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1 -> sMEM.
- sMEM:
  - sw: mWR=1, PCWre=1 -> sIF.
  - lw: mRD=1 -> sWB_LD.
- sWB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1 -> sIF.
- Invariants:
  - PCWre is 1 in exactly one cycle per instruction: the last cycle.
  - RegWre and mWR are never both 1.
  - Outputs are combinational from (state, opCode, zero, sign); state is the only register besides halt.
- Latencies (cycles):
  - j / jr / jal / nop: 2
  - branch: 3
  - ALU: 4
  - sw: 4
  - lw: 5

Decomposition:
- Shared package mc_cpu_pkg: state encodings, opcode constants, ALUOp codes, RegDst and PCSrc codes.
- One sub-module, mc_ctrl_decode: purely combinational (state, opCode, zero, sign) -> all control outputs and next_state.
- mc_control_fsm holds only the state and halt registers.

Test Plan:
- Reset high for 3 clk, then low -> state=000, IRWre=1 on the first cycle; PCWre=0 throughout reset.
- opCode=000000 (add) -> state sequence 000, 001, 110, 111, 000; in state 111: RegWre=1, RegDst=10, PCWre=1, ALUOp was 000 in state 110.
- opCode=100111 (lw) -> states 000, 001, 010, 011, 100; mRD=1 in 011 and 100; RegWre=1 only in 100; PCWre pulses once.
- opCode=110000 (beq):
  - zero=1 -> in state 101 PCSrc=01, PCWre=1.
  - zero=0 -> PCSrc=00.
  - Repeat with bne and with bltz (sign=1 / 0).
- opCode=111010 (jal) -> in state 001: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11; next state 000.
- opCode=111111 (halt) -> PCWre stays 0 and IRWre=0 for 20 cycles; Reset pulse restores normal fetch. Reset asserted during state 011 of an sw -> mWR=0 in that cycle, state=000 next.
